fan_pwm_driver: RTL and testbench
=================================

Name: fan_pwm_driver

Overview:
- Consumes the signed PID controller output and drives the fan's PWM pin with a glitch-free duty cycle.
- Duty is sampled only at PWM period boundaries.
- Provides a kick-start burst at full duty when the fan starts from standstill.
- Generates the clk_en_PID strobe that paces the PID core once every N PWM periods, closing the control loop.

Parameters:
- ADC_BITWIDTH, 8, magnitude width of the control value; ctrl_value_i is ADC_BITWIDTH+1 bits signed.
- PRESCALER_BITWIDTH, 4, width of the runtime prescaler setting.
- KICK_PERIODS, 4, number of full-duty PWM periods applied on a start from duty 0.
- PID_DIV, 2, PWM periods per clk_en_PID_o pulse (≥1).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- enable_i  in  1  driver enable; low forces fan off
- prescale_i  in  PRESCALER_BITWIDTH  tick every prescale_i+1 clocks
- kick_en_i  in  1  enables the kick-start feature
- ctrl_value_i  in  ADC_BITWIDTH+1 signed  PID output (out_Val_o of the PID core)
- pwm_o  out  1  registered PWM output to fan
- clk_en_PID_o  out  1  one-clock PID update strobe
- duty_o  out  ADC_BITWIDTH  duty currently in effect
- kick_o  out  1  high while in KICK state

Behaviour:
- Reset (async, rstn_i=0): pwm_o=0, clk_en_PID_o=0, duty_o=0, kick_o=0, all counters 0, state OFF.
- Prescaler: counts 0..prescale_i; tick on the clock where count==prescale_i, then count returns to 0. prescale_i=0 gives a tick every clock. prescale_i changes take effect on the next compare.
- PWM counter cnt: advances on tick over 0..MAXC-1 with MAXC=2^ADC_BITWIDTH-1 (255), wrapping to 0. Wrap edge = period boundary. Period = MAXC ticks.
- Clamp: req = 0 if ctrl_value_i<0, else ctrl_value_i[ADC_BITWIDTH-1:0]. The sign bit is the only overflow source; the range maxes at 255.
- Duty sampling: req is evaluated only at a period boundary (and on the first tick after enable rises).
- pwm_o: registered. On each tick edge, pwm_o <= (new cnt < duty in effect for the new period). duty 0 gives constant 0; duty 255 gives constant 1. No other output glitches.
- FSM states, each evaluated at a boundary:
  - OFF: duty 0.
    - req==0: stay OFF.
    - req>0 and kick_en_i: go to KICK, duty=255, kick counter=0.
    - req>0 and not kick_en_i: go to RUN, duty=req.
  - KICK: duty 255, kick counter increments per period.
    - req==0: go to OFF, duty 0 (abort).
    - kick counter==KICK_PERIODS-1: go to RUN, duty=req.
    - Otherwise stay in KICK.
  - RUN: duty=req.
    - req==0: go to OFF.
- kick_en_i is sampled only when leaving OFF; deasserting it during KICK does not abort the kick.
- duty_o and kick_o update on the same edge as the first pwm_o value of the new period.
- PID strobe: a period counter counts boundaries modulo PID_DIV. clk_en_PID_o=1 for exactly one clock, on the clock after a boundary edge where the period counter wraps. The strobe is independent of FSM state. The PID output settles before the next sample, so its latency is one period minimum.
- enable_i=0 (synchronous): next edge sets pwm_o=0, duty_o=0, kick_o=0, state OFF, all counters 0, strobe suppressed. Rising enable_i: the prescaler starts from 0, the first tick is treated as a boundary, and the strobe period counter starts at 0.
- Simultaneous boundary and enable_i=0: disable wins.
- Reset mid-kick or mid-period: immediate return to reset values; no partial period completes.

Test Plan:
- Rst, enable=1, prescale=0, kick_en=1, ctrl=64 → kick_o=1 and pwm_o constantly high for 4×255=1020 clocks, then duty_o=64 and pwm_o high 64 / low 191 clocks per period.
- kick_en=0, ctrl=-5 then ctrl=255 → duty_o stays 0 and pwm_o=0; after the next boundary duty_o=255 and pwm_o constantly 1 with no low clock.
- RUN at duty 100, change ctrl to 30 mid-period → the current period still ends with exactly 100 high ticks; the next period has 30 high ticks.
- PID_DIV=2, prescale=3 → clk_en_PID_o is a single-clock pulse every 2×255×4=2040 clocks. Verify it never coincides with a reset or disabled interval.
- During KICK (period 2), ctrl=0 → the next boundary enters OFF with pwm_o=0 and kick_o=0. Separately, drop enable_i mid-period → pwm_o=0 on the next edge.
- Assert rstn_i low asynchronously mid-kick (between clock edges) → all outputs are 0 immediately. After release with ctrl=50 and kick_en=1, the full 4-period kick restarts.

Source files
------------

// File: rtl/fan_pwm_driver.sv
// fan_pwm_driver
// Turns the signed PID controller output into a glitch-free PWM drive for a fan.
// Duty is only re-evaluated at PWM period boundaries. A start from standstill
// can be preceded by a kick-start burst at full duty. The driver also paces the
// PID core with clk_en_PID_o, once every PID_DIV PWM periods.
//
// Ports
//   clk_i         system clock
//   rstn_i        asynchronous active-low reset
//   enable_i      driver enable; low forces the fan off on the next edge
//   prescale_i    PWM tick every prescale_i+1 clocks
//   kick_en_i     allow the kick-start burst when leaving OFF
//   ctrl_value_i  signed PID output; negative values clamp to 0
//   pwm_o         registered PWM drive
//   clk_en_PID_o  one-clock PID update strobe
//   duty_o        duty in effect for the current period
//   kick_o        high while the kick-start burst is running
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | fan stopped, duty 0, waiting for a non-zero request
// KICK  | full-duty burst of KICK_PERIODS periods before regulating
// RUN   | duty follows the clamped request, sampled once per period
module fan_pwm_driver #(
   parameter int ADC_BITWIDTH       = 8,
   parameter int PRESCALER_BITWIDTH = 4,
   parameter int KICK_PERIODS       = 4,
   parameter int PID_DIV            = 2
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          enable_i,
   input  logic [PRESCALER_BITWIDTH-1:0] prescale_i,
   input  logic                          kick_en_i,
   input  logic signed [ADC_BITWIDTH:0]  ctrl_value_i,
   output logic                          pwm_o,
   output logic                          clk_en_PID_o,
   output logic [ADC_BITWIDTH-1:0]       duty_o,
   output logic                          kick_o
);

   localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
   localparam int PW = (PID_DIV > 1) ? $clog2(PID_DIV) : 1;

   localparam logic [ADC_BITWIDTH-1:0] DUTY_FULL = '1;
   // Last PWM count of a period: the period is 2^N-1 ticks so that full duty
   // keeps the output permanently high.
   localparam logic [ADC_BITWIDTH-1:0] CNT_LAST  = {{(ADC_BITWIDTH-1){1'b1}}, 1'b0};
   localparam logic [KW-1:0]           KICK_LAST = KW'(KICK_PERIODS - 1);
   localparam logic [PW-1:0]           PID_LAST  = PW'(PID_DIV - 1);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_KICK = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [ADC_BITWIDTH-1:0]         duty_q, duty_d;
   logic [KW-1:0]                   kick_cnt_q, kick_cnt_d;
   logic [PRESCALER_BITWIDTH-1:0]   pre_cnt_q;
   logic [ADC_BITWIDTH-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]                   per_cnt_q;
   logic                            first_q;
   logic                            pwm_q;
   logic                            strobe_q;
   logic [ADC_BITWIDTH-1:0]         req;
   logic                            req_zero;
   logic                            tick;
   logic                            boundary;

   // Negative requests are the only overflow case; the magnitude range tops out
   // at full duty.
   assign req      = ctrl_value_i[ADC_BITWIDTH] ? '0 : ctrl_value_i[ADC_BITWIDTH-1:0];
   assign req_zero = (req == '0);

   assign tick     = enable_i && (pre_cnt_q == prescale_i);
   // first_q turns the first tick after enable into a period boundary so the
   // request is picked up immediately instead of after a full idle period.
   assign boundary = tick && (first_q || (cnt_q == CNT_LAST));
   assign cnt_d    = boundary ? '0 : cnt_q + ADC_BITWIDTH'(1);

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      kick_cnt_d = kick_cnt_q;
      if (boundary) begin
         case (state_q)
            S_OFF: begin
               if (!req_zero) begin
                  if (kick_en_i) begin
                     state_d    = S_KICK;
                     duty_d     = DUTY_FULL;
                     kick_cnt_d = '0;
                  end else begin
                     state_d = S_RUN;
                     duty_d  = req;
                  end
               end
            end
            S_KICK: begin
               if (req_zero) begin
                  state_d    = S_OFF;
                  duty_d     = '0;
                  kick_cnt_d = '0;
               end else if (kick_cnt_q == KICK_LAST) begin
                  state_d    = S_RUN;
                  duty_d     = req;
                  kick_cnt_d = '0;
               end else begin
                  kick_cnt_d = kick_cnt_q + KW'(1);
               end
            end
            S_RUN: begin
               if (req_zero) begin
                  state_d = S_OFF;
                  duty_d  = '0;
               end else begin
                  duty_d = req;
               end
            end
            default: begin
               state_d    = S_OFF;
               duty_d     = '0;
               kick_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_OFF;
         duty_q     <= '0;
         kick_cnt_q <= '0;
      end else if (!enable_i) begin
         state_q    <= S_OFF;
         duty_q     <= '0;
         kick_cnt_q <= '0;
      end else if (tick) begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         kick_cnt_q <= kick_cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pre_cnt_q <= '0;
         cnt_q     <= '0;
         per_cnt_q <= '0;
         first_q   <= 1'b1;
         pwm_q     <= 1'b0;
         strobe_q  <= 1'b0;
      end else if (!enable_i) begin
         pre_cnt_q <= '0;
         cnt_q     <= '0;
         per_cnt_q <= '0;
         first_q   <= 1'b1;
         pwm_q     <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         pre_cnt_q <= tick ? '0 : pre_cnt_q + PRESCALER_BITWIDTH'(1);
         strobe_q  <= boundary && (per_cnt_q == PID_LAST);
         if (tick) begin
            cnt_q   <= cnt_d;
            // Compare against the duty of the period being entered, so the
            // boundary edge already carries the new period's first level.
            pwm_q   <= (cnt_d < duty_d);
            first_q <= 1'b0;
         end
         if (boundary) begin
            per_cnt_q <= (per_cnt_q == PID_LAST) ? '0 : per_cnt_q + PW'(1);
         end
      end
   end

   assign pwm_o        = pwm_q;
   assign clk_en_PID_o = strobe_q;
   assign duty_o       = duty_q;
   assign kick_o       = (state_q == S_KICK);

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Bench for fan_pwm_driver. A period-level reference model derives tick and
// boundary positions arithmetically from the number of enabled clocks and
// applies the OFF/KICK/RUN rules once per boundary.
module tb_fan_pwm_driver;

   localparam int AW = 8;
   localparam int PB = 4;
   localparam int KP = 4;
   localparam int PD = 2;
   localparam int MAXC = 255;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b1;
   logic                 enable = 1'b0;
   logic [PB-1:0]        prescale = '0;
   logic                 kick_en = 1'b0;
   logic signed [AW:0]   ctrl_v = '0;
   logic                 pwm;
   logic                 strobe;
   logic [AW-1:0]        duty;
   logic                 kick;

   fan_pwm_driver #(
      .ADC_BITWIDTH(AW),
      .PRESCALER_BITWIDTH(PB),
      .KICK_PERIODS(KP),
      .PID_DIV(PD)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .enable_i(enable),
      .prescale_i(prescale),
      .kick_en_i(kick_en),
      .ctrl_value_i(ctrl_v),
      .pwm_o(pwm),
      .clk_en_PID_o(strobe),
      .duty_o(duty),
      .kick_o(kick)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int strobe_cyc[$];

   // reference model: mode 0=off 1=kick 2=run
   int en_edges = 0;
   int mode = 0;
   int kcnt = 0;
   int m_duty = 0;
   bit m_pwm = 0;
   bit m_strobe = 0;
   bit m_bnd = 0;

   function automatic int req_of();
      int c;
      c = int'(ctrl_v);
      return (c < 0) ? 0 : c;
   endfunction

   task automatic model_zero();
      en_edges = 0;
      mode = 0;
      kcnt = 0;
      m_duty = 0;
      m_pwm = 0;
      m_strobe = 0;
      m_bnd = 0;
   endtask

   task automatic model_boundary(input int r);
      case (mode)
         0: if (r > 0) begin
               if (kick_en) begin
                  mode = 1; m_duty = 255; kcnt = 0;
               end else begin
                  mode = 2; m_duty = r;
               end
            end
         1: if (r == 0) begin
               mode = 0; m_duty = 0; kcnt = 0;
            end else if (kcnt == KP - 1) begin
               mode = 2; m_duty = r; kcnt = 0;
            end else begin
               kcnt++;
            end
         default: if (r == 0) begin
               mode = 0; m_duty = 0;
            end else begin
               m_duty = r;
            end
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("pwm_o", {31'd0, pwm}, {31'd0, m_pwm});
      check("clk_en_PID_o", {31'd0, strobe}, {31'd0, m_strobe});
      check("duty_o", {24'd0, duty}, m_duty);
      check("kick_o", {31'd0, kick}, (mode == 1) ? 32'd1 : 32'd0);
   endtask

   // Predict the effect of the coming clock edge from the current inputs,
   // then let the edge happen and compare.
   task automatic step();
      int p, n, t, k, j;
      m_bnd = 0;
      p = int'(prescale);
      if (!rstn || !enable) begin
         model_zero();
      end else begin
         n = en_edges;
         en_edges++;
         m_strobe = 0;
         if (n >= p && ((n - p) % (p + 1)) == 0) begin
            t = (n - p) / (p + 1);
            k = t / MAXC;
            j = t % MAXC;
            if (j == 0) begin
               m_bnd = 1;
               model_boundary(req_of());
               if (((k + 1) % PD) == 0) m_strobe = 1;
            end
            m_pwm = (j < m_duty);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (strobe === 1'b1) strobe_cyc.push_back(cyc);
      check_outputs();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic count_high(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         step();
         if (pwm === 1'b1) hi++;
      end
   endtask

   task automatic run_to_boundary();
      int budget;
      budget = 0;
      do begin
         step();
         budget++;
      end while (!m_bnd && budget < 8192);
      if (!m_bnd) begin
         vectors++;
         miscompares++;
         $error("FAIL boundary_timeout: observed %0d cycles expected < 8192", budget);
      end
   endtask

   function automatic logic signed [AW:0] rand_ctrl();
      int sel;
      int v;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) v = 0;
      else if (sel == 1) v = -int'($urandom_range(1, 256));
      else v = int'($urandom_range(1, 255));
      return 9'(v);
   endfunction

   initial begin
      int hi, h1, h2;

      // reset state
      #1 rstn = 1'b0;
      #2;
      model_zero();
      check_outputs();
      run(2);
      rstn = 1'b1;
      step();

      // kick-start from standstill at prescale 0
      prescale = 4'd0;
      kick_en = 1'b1;
      ctrl_v = 9'sd64;
      enable = 1'b1;
      run(1020);
      check("kick_held_1020", {31'd0, kick}, 32'd1);
      check("kick_duty_full", {24'd0, duty}, 32'd255);
      step();
      check("run_duty_64", {24'd0, duty}, 32'd64);
      check("kick_done", {31'd0, kick}, 32'd0);
      hi = int'(pwm);
      count_high(254, h1);
      check("high_clocks_64", hi + h1, 32'd64);

      // mid-period duty change only lands at the next boundary
      ctrl_v = 9'sd100;
      step();
      check("run_duty_100", {24'd0, duty}, 32'd100);
      hi = int'(pwm);
      count_high(49, h1);
      ctrl_v = 9'sd30;
      count_high(205, h2);
      check("high_clocks_100", hi + h1 + h2, 32'd100);
      step();
      hi = int'(pwm);
      count_high(254, h1);
      check("high_clocks_30", hi + h1, 32'd30);

      // negative request clamps to 0, then full duty without kick
      enable = 1'b0;
      step();
      kick_en = 1'b0;
      ctrl_v = -9'sd5;
      enable = 1'b1;
      run(300);
      check("neg_duty_zero", {24'd0, duty}, 32'd0);
      ctrl_v = 9'sd255;
      run_to_boundary();
      check("full_duty", {24'd0, duty}, 32'd255);
      hi = int'(pwm);
      count_high(254, h1);
      check("full_high_clocks", hi + h1, 32'd255);

      // kick aborted in its second period
      enable = 1'b0;
      step();
      prescale = 4'd1;
      kick_en = 1'b1;
      ctrl_v = 9'sd80;
      enable = 1'b1;
      run_to_boundary();
      run_to_boundary();
      run(200);
      ctrl_v = 9'sd0;
      run_to_boundary();
      check("abort_kick_o", {31'd0, kick}, 32'd0);
      check("abort_pwm_o", {31'd0, pwm}, 32'd0);
      check("abort_duty_o", {24'd0, duty}, 32'd0);

      // disable mid-period
      kick_en = 1'b0;
      ctrl_v = 9'sd120;
      run_to_boundary();
      check("run_duty_120", {24'd0, duty}, 32'd120);
      run(100);
      enable = 1'b0;
      step();
      check("disable_pwm_o", {31'd0, pwm}, 32'd0);
      check("disable_duty_o", {24'd0, duty}, 32'd0);
      run(3);

      // asynchronous reset mid-kick, then a full kick again
      prescale = 4'd0;
      kick_en = 1'b1;
      ctrl_v = 9'sd50;
      enable = 1'b1;
      run(300);
      #3 rstn = 1'b0;
      #1;
      model_zero();
      check("async_rst_pwm_o", {31'd0, pwm}, 32'd0);
      check("async_rst_kick_o", {31'd0, kick}, 32'd0);
      check("async_rst_duty_o", {24'd0, duty}, 32'd0);
      check("async_rst_strobe", {31'd0, strobe}, 32'd0);
      run(2);
      rstn = 1'b1;
      step();
      check("rekick_start", {31'd0, kick}, 32'd1);
      kick_en = 1'b0;
      run(1019);
      check("rekick_held", {31'd0, kick}, 32'd1);
      step();
      check("rekick_done", {31'd0, kick}, 32'd0);
      check("rekick_duty_50", {24'd0, duty}, 32'd50);

      // PID strobe spacing at prescale 3 with random requests
      enable = 1'b0;
      step();
      prescale = 4'd3;
      ctrl_v = 9'sd200;
      strobe_cyc.delete();
      enable = 1'b1;
      for (int c = 0; c < 17; c++) begin
         run(600);
         ctrl_v = rand_ctrl();
      end
      run(20);
      check("strobe_count", strobe_cyc.size(), 32'd5);
      for (int i = 1; i < strobe_cyc.size(); i++)
         check("strobe_spacing", strobe_cyc[i] - strobe_cyc[i-1], 32'd2040);

      // randomized sessions
      for (int s = 0; s < 10; s++) begin
         enable = 1'b0;
         step();
         prescale = 4'($urandom_range(0, 2));
         kick_en = 1'($urandom_range(0, 1));
         ctrl_v = rand_ctrl();
         enable = 1'b1;
         for (int c = 0; c < 6; c++) begin
            run(int'($urandom_range(50, 400)));
            ctrl_v = rand_ctrl();
            kick_en = 1'($urandom_range(0, 1));
         end
      end
      enable = 1'b0;
      run(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
